npu_cmd_queue: RTL and testbench
================================

NPU_CMD_QUEUE -- requirements
Module: npu_cmd_queue

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning instruction/word width.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of 2, >= 2.
REQ-003 The module SHALL have parameter MAX_OUT, default 4, meaning max instructions issued to the core without a returned result; >= 1.
REQ-004 The module SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 The module SHALL have port s_data, input, DATA_WIDTH, instruction word from the PCIe host side.
REQ-007 The module SHALL have port s_valid, input, 1, s_data valid.
REQ-008 The module SHALL have port s_ready, output, 1, queue can accept s_data.
REQ-009 The module SHALL have port m_data, output, DATA_WIDTH, instruction to npu_core host_data_in.
REQ-010 The module SHALL have port m_valid, output, 1, m_data valid; drives npu_core host_data_in_valid.
REQ-011 The module SHALL have port m_ready, input, 1, from npu_core host_data_in_ready.
REQ-012 The module SHALL have port rsp_fire, input, 1, one-cycle pulse per result accepted from npu_core (host_data_out_valid && host_data_out_ready).
REQ-013 The module SHALL have port flush, input, 1, pulse requesting discard of queued instructions.
REQ-014 The module SHALL have port level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-015 The module SHALL have port outstanding, output, $clog2(MAX_OUT)+1, issued-but-unanswered count.
REQ-016 The module SHALL have port draining, output, 1, high while in state DRAIN.
REQ-017 The module SHALL have ports issued_cnt and done_cnt, output, 32 each, free-running issue/response counters.
REQ-018 The module SHALL have port rsp_err, output, 1, sticky: rsp_fire seen with outstanding == 0.

Function
REQ-019 The module SHALL implement a first-word-fall-through FIFO: m_data = head entry whenever level > 0.
REQ-020 The module SHALL push on s_valid && s_ready; s_ready = (level < DEPTH) && state == RUN, combinational from registered state.
REQ-021 When full, s_ready SHALL be 0 even if a pop occurs in the same cycle (no full-bypass).
REQ-022 m_valid SHALL be (level > 0) && (outstanding < MAX_OUT) && state == RUN.
REQ-023 The module SHALL pop and issue on m_valid && m_ready; m_data/m_valid SHALL be held stable while m_valid && !m_ready.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 Latency from an accepted push into an empty FIFO to m_valid SHALL be 1 cycle.
REQ-026 outstanding SHALL increment on issue, decrement on rsp_fire, and be unchanged when both occur in one cycle.
REQ-027 rsp_fire with outstanding == 0 and no same-cycle issue SHALL leave outstanding at 0 and set rsp_err until reset.
REQ-028 issued_cnt/done_cnt SHALL increment on issue/rsp_fire respectively and wrap 0xFFFFFFFF -> 0; done_cnt SHALL not increment on a REQ-027 error.
REQ-029 The state machine SHALL have states RUN and DRAIN; reset state RUN.
REQ-030 In RUN, flush SHALL, on that edge, set level = 0, reset both pointers, and go to DRAIN; a same-cycle push SHALL be discarded.
REQ-031 In DRAIN, s_ready = 0 and m_valid = 0; flush SHALL be ignored; rsp_fire SHALL still decrement outstanding.
REQ-032 DRAIN SHALL return to RUN on the edge where outstanding is 0 (including entry with outstanding already 0, i.e. DRAIN lasts at least 1 cycle).

Reset
REQ-033 While rst_n is low at a clk edge: level = 0, pointers = 0, outstanding = 0, state = RUN, issued_cnt = done_cnt = 0, rsp_err = 0; m_valid = 0, s_ready = 0 in reset cycle, s_ready = 1 the cycle after release.
REQ-034 Reset SHALL take priority over flush, push, pop and rsp_fire, including mid-DRAIN; FIFO RAM contents need not be cleared.

Verification
REQ-035 Push 0x01640C800 words A,B,C with m_ready = 1, one rsp_fire 3 cycles after each issue -> m_data A,B,C in order, issued_cnt = done_cnt = 3, outstanding back to 0.
REQ-036 m_ready = 1, no rsp_fire, push 6 words -> exactly 4 issued, m_valid = 0 with level = 2, outstanding = 4; one rsp_fire -> 5th word issues next cycle.
REQ-037 m_ready = 0, push 17 words -> s_ready drops after 16th, level = 16; one pop with s_valid high -> no push that cycle, level = 15, then push next cycle -> 16.
REQ-038 level = 5, outstanding = 2, pulse flush -> next cycle level = 0, draining = 1, s_ready = 0; two rsp_fire -> draining = 0 after second, s_ready = 1.
REQ-039 Idle, rsp_fire pulse -> rsp_err = 1, outstanding = 0, done_cnt = 0; rsp_err stays 1 until rst_n low.
REQ-040 Assert rst_n low mid-DRAIN with level = 3 -> all REQ-033 values; after release, new push issues normally.

Source files
------------

// File: rtl/npu_cmd_queue.sv
// npu_cmd_queue: a first-word-fall-through instruction FIFO that sits between
// the PCIe host side and npu_core. It limits how many instructions can be in
// flight in the core before their results come back. A flush empties the queue
// and then waits, in DRAIN, until every instruction already issued has answered.
module npu_cmd_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_OUT    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         rsp_fire,
  input  logic                         flush,
  output logic [$clog2(DEPTH):0]       level,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         draining,
  output logic [31:0]                  issued_cnt,
  output logic [31:0]                  done_cnt,
  output logic                         rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push, pop, flush_run, rsp_bad, rsp_ok;

  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign flush_run = (state == RUN) && flush;
  // A response with nothing in flight is only legal if an issue happens in the same cycle.
  assign rsp_bad   = rsp_fire && (outstanding == '0) && !pop;
  assign rsp_ok    = rsp_fire && !rsp_bad;
  assign m_data    = mem[rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next-state logic: flush enters DRAIN, DRAIN leaves once nothing is in flight.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    state_next = state;
    case (state)
      RUN:     if (flush)              state_next = DRAIN;
      DRAIN:   if (outstanding == '0)  state_next = RUN;
      default:                         state_next = RUN;
    endcase
  end

  // Output logic: handshakes only in RUN, and never while reset is asserted.
  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    draining = (state == DRAIN);
    if (rst_n && state == RUN) begin
      // Full means not ready, even when a pop is happening this cycle.
      s_ready = (level < LW'(DEPTH));
      m_valid = (level != '0) && (outstanding < OW'(MAX_OUT));
    end
  end

  // Storage array; a word written during a flush cycle is discarded.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset; occupancy is tracked by the
    // pointers and level, so stale contents are never presented as valid.
    if (push && !flush_run) mem[wr_ptr] <= s_data;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (a power of 2).
  always_ff @(posedge clk) begin
    if (!rst_n || flush_run) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // In-flight count: up on issue, down on an accepted response, both cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({pop, rsp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Free-running counters and the sticky stray-response flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      done_cnt   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop)     issued_cnt <= issued_cnt + 32'd1;
      if (rsp_ok)  done_cnt   <= done_cnt + 32'd1;
      if (rsp_bad) rsp_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_npu_cmd_queue.sv
// Directed testbench for npu_cmd_queue. Every word the bench pushes goes into
// an expected-order queue; a monitor on the falling edge pops and compares each
// issued instruction, while the main sequence checks status outputs directly.
module tb_npu_cmd_queue;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int MAX_OUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic            rsp_fire;
  logic            flush;
  logic [4:0]      level;
  logic [2:0]      outstanding;
  logic            draining;
  logic [31:0]     issued_cnt;
  logic [31:0]     done_cnt;
  logic            rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  npu_cmd_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rsp_fire(rsp_fire),
    .flush(flush), .level(level), .outstanding(outstanding), .draining(draining),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted, bounded by a cycle budget.
  task automatic push_word(input logic [DW-1:0] d);
    int budget;
    budget = 100;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && budget > 0) begin
      step();
      budget--;
    end
    check("push_accept_timeout", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(d);
    step();
    s_valid = 1'b0;
  endtask

  // Scoreboard monitor: a handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got 0x%0h, expected no issue", m_data);
      end else begin
        check("issue_data", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    rsp_fire = 1'b0; flush = 1'b0;

    // Reset values.
    step(); step();
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_outstanding", {29'd0, outstanding}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_draining", {31'd0, draining}, 32'd0);
    check("rst_issued", issued_cnt, 32'd0);
    check("rst_done", done_cnt, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    step();
    check("release_s_ready", {31'd0, s_ready}, 32'd1);

    // Three words in order, each answered three cycles after it issues.
    m_ready = 1'b1;
    begin
      logic [DW-1:0] words [3];
      words[0] = 32'h1640_C800; words[1] = 32'h1640_C801; words[2] = 32'h1640_C802;
      for (int i = 0; i < 3; i++) begin
        push_word(words[i]);
        check("fwft_latency", {31'd0, m_valid}, 32'd1);
        step();
        step(); step();
        rsp_fire = 1'b1; step(); rsp_fire = 1'b0;
      end
    end
    check("seq_issued", issued_cnt, 32'd3);
    check("seq_done", done_cnt, 32'd3);
    check("seq_outstanding", {29'd0, outstanding}, 32'd0);

    // Outstanding limit: six words, no responses, only four may issue.
    for (int i = 0; i < 6; i++) begin
      s_data = 32'hA000_0000 + i; s_valid = 1'b1;
      exp_q.push_back(32'hA000_0000 + i);
      step();
    end
    s_valid = 1'b0;
    check("lim_m_valid", {31'd0, m_valid}, 32'd0);
    check("lim_level", {27'd0, level}, 32'd2);
    check("lim_outstanding", {29'd0, outstanding}, 32'd4);
    check("lim_issued", issued_cnt, 32'd7);
    rsp_fire = 1'b1; step(); rsp_fire = 1'b0;
    check("lim_resume_valid", {31'd0, m_valid}, 32'd1);
    step();
    check("lim_refill_outstanding", {29'd0, outstanding}, 32'd4);
    check("lim_refill_level", {27'd0, level}, 32'd1);
    rsp_fire = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rsp_fire = 1'b0;
    check("lim_end_outstanding", {29'd0, outstanding}, 32'd0);
    check("lim_end_level", {27'd0, level}, 32'd0);
    check("lim_end_done", done_cnt, 32'd9);

    // Full FIFO: no bypass on a same-cycle pop, then the pending word goes in.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 32'hB000_0000 + i;
      exp_q.push_back(32'hB000_0000 + i);
      step();
    end
    s_data = 32'hB000_0010;
    check("full_level", {27'd0, level}, 32'd16);
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    m_ready = 1'b1;
    check("full_pop_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    m_ready = 1'b0;
    check("full_after_pop_level", {27'd0, level}, 32'd15);
    check("full_after_pop_s_ready", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(32'hB000_0010);
    step();
    s_valid = 1'b0;
    check("full_refill_level", {27'd0, level}, 32'd16);
    m_ready = 1'b1; rsp_fire = 1'b1;
    for (int i = 0; i < 17; i++) step();
    m_ready = 1'b0; rsp_fire = 1'b0;
    check("full_drain_level", {27'd0, level}, 32'd0);
    check("full_drain_outstanding", {29'd0, outstanding}, 32'd0);
    check("full_issued", issued_cnt, 32'd26);
    check("full_done", done_cnt, 32'd26);

    // Flush with level 5 and two in flight; DRAIN ends once both have answered.
    for (int i = 0; i < 7; i++) begin
      s_data = 32'hC000_0000 + i; s_valid = 1'b1;
      exp_q.push_back(32'hC000_0000 + i);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1; step(); step(); m_ready = 1'b0;
    check("pre_flush_level", {27'd0, level}, 32'd5);
    check("pre_flush_outstanding", {29'd0, outstanding}, 32'd2);
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; s_valid = 1'b0;
    exp_q.delete();
    check("flush_level", {27'd0, level}, 32'd0);
    check("flush_draining", {31'd0, draining}, 32'd1);
    check("flush_s_ready", {31'd0, s_ready}, 32'd0);
    check("flush_m_valid", {31'd0, m_valid}, 32'd0);
    rsp_fire = 1'b1; step();
    check("drain_mid_outstanding", {29'd0, outstanding}, 32'd1);
    step(); rsp_fire = 1'b0;
    step();
    check("drain_exit_draining", {31'd0, draining}, 32'd0);
    check("drain_exit_s_ready", {31'd0, s_ready}, 32'd1);
    check("drain_exit_level", {27'd0, level}, 32'd0);
    check("drain_done", done_cnt, 32'd28);

    // Stray response while idle sets the sticky error only.
    rsp_fire = 1'b1; step(); rsp_fire = 1'b0;
    check("err_set", {31'd0, rsp_err}, 32'd1);
    check("err_outstanding", {29'd0, outstanding}, 32'd0);
    check("err_done", done_cnt, 32'd28);
    step(); step(); step();
    check("err_sticky", {31'd0, rsp_err}, 32'd1);

    // Reset in the middle of DRAIN, with flush, push and response all asserted.
    m_ready = 1'b1;
    push_word(32'hE000_0000);
    step();
    m_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      s_data = 32'hE000_0000 + i; s_valid = 1'b1;
      exp_q.push_back(32'hE000_0000 + i);
      step();
    end
    s_valid = 1'b0;
    check("pre_rst_level", {27'd0, level}, 32'd3);
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.delete();
    check("pre_rst_draining", {31'd0, draining}, 32'd1);
    rst_n = 1'b0; flush = 1'b1; s_valid = 1'b1; rsp_fire = 1'b1; m_ready = 1'b1;
    step();
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_outstanding", {29'd0, outstanding}, 32'd0);
    check("mid_rst_draining", {31'd0, draining}, 32'd0);
    check("mid_rst_issued", issued_cnt, 32'd0);
    check("mid_rst_done", done_cnt, 32'd0);
    check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    flush = 1'b0; s_valid = 1'b0; rsp_fire = 1'b0; m_ready = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b1;
    push_word(32'hF00D_0001);
    check("post_rst_m_valid", {31'd0, m_valid}, 32'd1);
    step();
    m_ready = 1'b0;
    check("post_rst_issued", issued_cnt, 32'd1);
    check("post_rst_outstanding", {29'd0, outstanding}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
